// File: rtl/xram_arb_pkg.sv
// Shared types and constants for the XRAM port arbiter.
package xram_arb_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned OWNER_W         = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned TMO_CNT_W       = 16;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_RELEASE = 2'b10
  } arb_state_e;

  // Next requester index after idx, wrapping at n.
  function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx,
                                                 input int unsigned n);
    return (32'(idx) == n - 1) ? '0 : idx + OWNER_W'(1);
  endfunction

endpackage

// File: rtl/xram_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first asserted request at or after rr_ptr_i.
module rr_pick
  import xram_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0]   req_i,
  input  logic [OWNER_W-1:0] rr_ptr_i,
  output logic [OWNER_W-1:0] winner_o,
  output logic               any_req_o
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [OWNER_W:0]   idx_sum;
  logic               found;

  // Rotate so bit 0 is the pointer position, then map the first hit back.
  always_comb begin
    req_dbl  = {req_i, req_i};
    req_rot  = N_REQ'(req_dbl >> rr_ptr_i);
    winner_o = '0;
    found    = 1'b0;
    idx_sum  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        idx_sum = {1'b0, rr_ptr_i} + (OWNER_W+1)'(k);
        if (idx_sum >= (OWNER_W+1)'(N_REQ)) begin
          idx_sum = idx_sum - (OWNER_W+1)'(N_REQ);
        end
        winner_o = idx_sum[OWNER_W-1:0];
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/xram_arbiter.sv
// Per-access round-robin arbiter sharing the XRAM port; port 0 is the CPU.
// Optional BUSY watchdog enabled by defining XRAM_ARB_TIMEOUT_EN.
module xram_arbiter
  import xram_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_stb,
  input  logic [N_REQ-1:0]          req_wr,
  input  logic [ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [DATA_W*N_REQ-1:0]   req_data_out,
  output logic [N_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]         req_data_in,
  output logic [ADDR_W-1:0]         xram_addr,
  output logic [DATA_W-1:0]         xram_data_out,
  output logic                      xram_wr,
  output logic                      xram_stb,
  input  logic [DATA_W-1:0]         xram_data_in,
  input  logic                      xram_ack,
  output logic                      arb_busy,
  output logic [OWNER_W-1:0]        arb_owner,
  output logic                      arb_timeout
);

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0] winner;
  logic               any_req;
  logic               tmo_fire;

  logic               sel_stb;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [N_REQ-1:0]   grant_oh;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_i     (req_stb),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Granted requester's bus fields.
  always_comb begin
    sel_stb  = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    grant_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == OWNER_W'(i)) begin
        sel_stb     = req_stb[i];
        sel_wr      = req_wr[i];
        sel_addr    = req_addr[i*ADDR_W +: ADDR_W];
        sel_data    = req_data_out[i*DATA_W +: DATA_W];
        grant_oh[i] = 1'b1;
      end
    end
  end

`ifdef XRAM_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_q;

  // Counter is held at zero outside BUSY, so it is clear on every BUSY entry.
  always_comb begin
    tmo_fire  = (state_q == ST_BUSY) && !xram_ack &&
                (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d = (state_q == ST_BUSY) ? tmo_cnt_q + TMO_CNT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_q | tmo_fire;
    end
  end

  assign arb_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign tmo_fire           = 1'b0;
  assign arb_timeout        = 1'b0;
  assign unused_timeout_cfg = ^TMO_CNT_W'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state and bus steering; the XRAM side is only driven in BUSY.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    xram_stb      = 1'b0;
    xram_wr       = 1'b0;
    xram_addr     = '0;
    xram_data_out = '0;
    req_ack       = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        xram_stb      = sel_stb;
        xram_wr       = sel_wr;
        xram_addr     = sel_addr;
        xram_data_out = sel_data;
        req_ack       = grant_oh & {N_REQ{xram_ack | tmo_fire}};
        if (xram_ack || !sel_stb || tmo_fire) begin
          state_d  = ST_RELEASE;
          rr_ptr_d = rr_next(grant_q, N_REQ);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign req_data_in = tmo_fire ? TIMEOUT_DATA : xram_data_in;
  assign arb_busy    = (state_q == ST_BUSY);
  assign arb_owner   = (state_q == ST_IDLE) ? '0 : grant_q;

endmodule

// File: tb/tb_xram_arbiter.sv
// Directed bench for xram_arbiter with a programmable-latency XRAM model.
module tb_xram_arbiter;
  import xram_arb_pkg::*;

  localparam int unsigned N = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_stb;
  logic [N-1:0]     req_wr;
  logic [16*N-1:0]  req_addr;
  logic [8*N-1:0]   req_data_out;
  logic [N-1:0]     req_ack;
  logic [7:0]       req_data_in;
  logic [15:0]      xram_addr;
  logic [7:0]       xram_data_out;
  logic             xram_wr;
  logic             xram_stb;
  logic [7:0]       xram_data_in;
  logic             xram_ack;
  logic             arb_busy;
  logic [2:0]       arb_owner;
  logic             arb_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int wait_cnt = 0;

  logic [15:0] exp_addr [3] = '{16'h0100, 16'h2BCD, 16'h3EF0};
  logic [7:0]  exp_data [3] = '{8'h11, 8'h5A, 8'hC3};
  logic        exp_wr   [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  xram_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_stb       (req_stb),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_data_out  (req_data_out),
    .req_ack       (req_ack),
    .req_data_in   (req_data_in),
    .xram_addr     (xram_addr),
    .xram_data_out (xram_data_out),
    .xram_wr       (xram_wr),
    .xram_stb      (xram_stb),
    .xram_data_in  (xram_data_in),
    .xram_ack      (xram_ack),
    .arb_busy      (arb_busy),
    .arb_owner     (arb_owner),
    .arb_timeout   (arb_timeout)
  );

  // XRAM model: acks once stb has been high for lat full cycles.
  always @(posedge clk) wait_cnt <= xram_stb ? wait_cnt + 1 : 0;
  assign xram_ack = xram_stb && (wait_cnt >= lat);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_stb = '0;
    lat     = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!arb_busy && c < 50);
    check(tag, 32'(arb_busy), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int cyc;
    int last;
    int exp_o;
    bit drop0;

    rst          = 1'b1;
    req_stb      = '0;
    req_wr       = {exp_wr[2], exp_wr[1], exp_wr[0]};
    req_addr     = {exp_addr[2], exp_addr[1], exp_addr[0]};
    req_data_out = {exp_data[2], exp_data[1], exp_data[0]};
    xram_data_in = 8'hA5;
    lat          = 2;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(arb_busy), 0);
    check("rst_owner", 32'(arb_owner), 0);
    check("rst_stb",   32'(xram_stb), 0);
    check("rst_ack",   32'(req_ack), 0);
    check("rst_tmo",   32'(arb_timeout), 0);
    rst = 1'b0;

    // Single CPU access with a 2-cycle XRAM.
    req_stb = 3'b001;
    @(negedge clk);
    check("t1_busy",  32'(arb_busy), 1);
    check("t1_stb",   32'(xram_stb), 1);
    check("t1_addr",  32'(xram_addr), 32'h0100);
    check("t1_wr",    32'(xram_wr), 0);
    check("t1_noack", 32'(req_ack), 0);
    @(negedge clk);
    check("t1_wait",  32'(req_ack), 0);
    @(negedge clk);
    check("t1_ack",   32'(req_ack), 3'b001);
    check("t1_rdata", 32'(req_data_in), 8'hA5);
    @(negedge clk);
    check("t1_rel_busy", 32'(arb_busy), 0);
    check("t1_rel_stb",  32'(xram_stb), 0);
    check("t1_rel_ack",  32'(req_ack), 0);
    req_stb = '0;
    @(negedge clk);
    check("t1_idle", 32'(arb_busy), 0);

    // All three requesting, zero-wait XRAM.
    do_reset();
    req_stb = 3'b111;
    k = 0; cyc = 0; last = 0;
    while (k < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (arb_busy) begin
        exp_o = k % 3;
        check($sformatf("t2_owner%0d", k), 32'(arb_owner), 32'(exp_o));
        check($sformatf("t2_addr%0d", k),  32'(xram_addr), 32'(exp_addr[exp_o]));
        check($sformatf("t2_data%0d", k),  32'(xram_data_out), 32'(exp_data[exp_o]));
        check($sformatf("t2_wr%0d", k),    32'(xram_wr), 32'(exp_wr[exp_o]));
        check($sformatf("t2_ack%0d", k),   32'(req_ack), 32'(1 << exp_o));
        if (k > 0) check($sformatf("t2_gap%0d", k), 32'(cyc - last), 3);
        last = cyc;
        k++;
      end
    end
    check("t2_done", 32'(k), 6);

    // Port 1 bursts; port 0 cuts in once.
    do_reset();
    req_stb = 3'b010;
    k = 0; cyc = 0; drop0 = 1'b0;
    while (k < 17 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (drop0) begin
        req_stb[0] = 1'b0;
        drop0 = 1'b0;
      end
      if (arb_busy) begin
        exp_o = (k == 4) ? 0 : 1;
        check($sformatf("t3_owner%0d", k), 32'(arb_owner), 32'(exp_o));
        if (arb_owner == 3'd0) drop0 = 1'b1;
        if (k == 3) req_stb[0] = 1'b1;
        k++;
      end
    end
    check("t3_done", 32'(k), 17);
    req_stb = '0;
    repeat (2) @(negedge clk);

    // Abort by port 2, then arbitration resumes at port 0.
    do_reset();
    lat = 1000;
    req_stb = 3'b100;
    wait_busy("t4_busy");
    check("t4_owner", 32'(arb_owner), 2);
    check("t4_addr",  32'(xram_addr), 32'h3EF0);
    check("t4_stb",   32'(xram_stb), 1);
    req_stb = '0;
    #1;
    check("t4_stb_drop", 32'(xram_stb), 0);
    check("t4_noack",    32'(req_ack), 0);
    @(negedge clk);
    check("t4_rel_busy", 32'(arb_busy), 0);
    check("t4_rel_ack",  32'(req_ack), 0);
    req_stb = 3'b111;
    lat = 0;
    wait_busy("t4_rearb");
    check("t4_rearb_owner", 32'(arb_owner), 0);
    req_stb = '0;
    repeat (3) @(negedge clk);

    // Reset while port 1 is mid-access.
    lat = 1000;
    req_stb = 3'b010;
    wait_busy("t5_busy");
    check("t5_owner", 32'(arb_owner), 1);
    check("t5_wr",    32'(xram_wr), 1);
    req_stb = 3'b011;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy",  32'(arb_busy), 0);
    check("t5_rst_owner", 32'(arb_owner), 0);
    check("t5_rst_stb",   32'(xram_stb), 0);
    check("t5_rst_addr",  32'(xram_addr), 0);
    check("t5_rst_wr",    32'(xram_wr), 0);
    check("t5_rst_data",  32'(xram_data_out), 0);
    check("t5_rst_ack",   32'(req_ack), 0);
    rst = 1'b0;
    lat = 0;
    wait_busy("t5_rearb");
    check("t5_rearb_owner", 32'(arb_owner), 0);
    req_stb = '0;
    repeat (3) @(negedge clk);

`ifdef XRAM_ARB_TIMEOUT_EN
    // XRAM never acks: watchdog releases the port after 8 BUSY cycles.
    do_reset();
    lat = 100000;
    req_stb = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("t6_busy%0d", c), 32'(arb_busy), 1);
      if (c < 8) begin
        check($sformatf("t6_noack%0d", c), 32'(req_ack), 0);
      end else begin
        check("t6_ack",   32'(req_ack), 3'b001);
        check("t6_rdata", 32'(req_data_in), 8'hFF);
      end
    end
    @(negedge clk);
    check("t6_tmo",      32'(arb_timeout), 1);
    check("t6_rel_busy", 32'(arb_busy), 0);
    req_stb = '0;
    repeat (5) @(negedge clk);
    check("t6_tmo_sticky", 32'(arb_timeout), 1);
`else
    check("tmo_off", 32'(arb_timeout), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xram_arbiter.md
Name: xram_arbiter

Overview:
Shares the single XRAM port among N requesters: the CPU/xiommu path on port 0 and the DMA-style accelerators (mem-write engine and others) on ports 1..N-1. Arbitration is round-robin and per access: every byte handshake is arbitrated separately, so a long accelerator burst cannot starve the CPU. The block sits between the requesters' xram_* buses and the XRAM model. It exposes owner/busy status for verification.

Parameters:
N_REQ, 3, number of requesters (2..8); port 0 is the CPU.
TIMEOUT_CYCLES, 255, cycles in BUSY without xram_ack before a timeout fires (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
req_stb  in  N_REQ  per-requester strobe; held high until acked
req_wr  in  N_REQ  per-requester write enable
req_addr  in  16*N_REQ  flattened addresses; requester i at [16i+15:16i]
req_data_out  in  8*N_REQ  flattened write data; requester i at [8i+7:8i]
req_ack  out  N_REQ  one-hot ack to the granted requester
req_data_in  out  8  XRAM read data, broadcast to all requesters
xram_addr  out  16  muxed address
xram_data_out  out  8  muxed write data
xram_wr  out  1  muxed write enable
xram_stb  out  1  strobe to XRAM
xram_data_in  in  8  read data from XRAM
xram_ack  in  1  XRAM completion
arb_busy  out  1  high in the BUSY state
arb_owner  out  3  index of the granted requester; 0 when idle
arb_timeout  out  1  sticky timeout flag (0 when the optional feature is off)

Behaviour:
- States: IDLE=2'b00, BUSY=2'b01, RELEASE=2'b10.
- IDLE: if any req_stb is high, pick a winner by round-robin starting at rr_ptr. Register grant←winner and move to BUSY on the next edge. Arbitration latency is 1 cycle.
- BUSY:
  - xram_stb = req_stb[grant].
  - xram_addr, xram_wr and xram_data_out are driven combinationally from the granted requester.
  - req_ack[grant] = xram_ack, combinational pass-through; all other ack bits are 0.
- BUSY, xram_ack=1: on the next edge go to RELEASE and set rr_ptr←(grant+1) mod N_REQ.
- BUSY, req_stb[grant] drops without an ack (abort): go to RELEASE; rr_ptr advances the same way.
- RELEASE: xram_stb=0 for exactly one bubble cycle, then IDLE. This keeps a combinationally-addressed requester from seeing a stale ack.
- Outside BUSY: xram_stb=0, xram_wr=0, xram_addr=16'h0000, xram_data_out=8'h00, req_ack=0.
- req_data_in = xram_data_in at all times.
- Ties: round-robin only. A requester that was just served has the lowest priority in the next arbitration.
- A requester whose stb rises while another is BUSY waits. Its worst-case wait is (N_REQ-1) accesses.
- Reset values: state=IDLE, grant=0, rr_ptr=0, all outputs 0. Reset mid-BUSY aborts the access; no ack is issued.
- arb_owner = grant in BUSY and RELEASE, 0 in IDLE. arb_busy = (state==BUSY).
- rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
XRAM_ARB_TIMEOUT_EN:
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle without xram_ack. When it reaches TIMEOUT_CYCLES:
  - req_ack[grant] pulses for 1 cycle with req_data_in forced to 8'hFF;
  - arb_timeout sets and stays set until rst;
  - the state goes to RELEASE.
- Undefined: no counter; arb_timeout is tied to 0; BUSY waits indefinitely.

Decomposition:
- Package xram_arb_pkg: state encodings, ADDR_W=16, DATA_W=8, the bus-slicing helper constants, and TIMEOUT default.
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any_req.
  - Instantiated once.

Test Plan:
1. Single requester: CPU stb, addr=16'h0100, wr=0, XRAM acks after 2 cycles with 8'hA5 → xram_addr=16'h0100 one cycle after stb; req_ack[0] pulses; req_data_in=8'hA5; one RELEASE cycle follows.
2. Contention: ports 0,1,2 all held high from reset, zero-wait XRAM → grant order 0,1,2,0,1,2; each grant is separated by RELEASE and IDLE cycles.
3. Burst fairness: port 1 keeps stb high for 16 accesses while port 0 requests once mid-burst → port 0 is served within 1 access of its request; port 1 resumes afterwards.
4. Abort: port 2 granted, its stb drops before the ack → xram_stb falls; no req_ack; the next arbitration starts at port 0.
5. Reset mid-BUSY: assert rst while port 1 is granted → all outputs 0 the next cycle; rr_ptr=0; port 0 wins the first arbitration after reset.
6. Timeout (XRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): XRAM never acks → req_ack pulses 8 cycles into BUSY with req_data_in=8'hFF; arb_timeout=1 and stays set.
